// File: rtl/berger_scrub_memory.sv
`default_nettype none
// ============================================================================
// berger_scrub_memory : Berger-coded single-port RAM with scrubber and error log
// Revision 1.0
// ============================================================================
module berger_scrub_memory #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 4,
   parameter int SCRUB_INTERVAL = 256,
   parameter int ERR_CNT_W      = 8,
   localparam int CHK_W         = $clog2(DATA_W + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [DATA_W-1:0]       req_wdata,
   input  logic [DATA_W+CHK_W-1:0] inj_mask,
   output logic                    rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_err,
   input  logic                    scrub_en,
   input  logic                    err_clr,
   output logic [ERR_CNT_W-1:0]    err_count,
   output logic [ADDR_W-1:0]       err_addr,
   output logic                    err_addr_valid,
   output logic                    init_done
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = DATA_W + CHK_W;
   localparam int CNT_W = $clog2(SCRUB_INTERVAL);

   localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [ADDR_W-1:0]    PTR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;
   localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
   localparam logic [CHK_W-1:0]     CHK_ONE   = CHK_W'(1);
   localparam logic [CW-1:0]        INIT_WORD = {CHK_W'(DATA_W), {DATA_W{1'b0}}};

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_t;

   function automatic logic [CHK_W-1:0] zeros_of(input logic [DATA_W-1:0] d);
      logic [CHK_W-1:0] n;
      n = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (!d[i]) n = n + CHK_ONE;
      end
      return n;
   endfunction

   function automatic logic berger_bad(input logic [CW-1:0] w);
      return zeros_of(w[DATA_W-1:0]) != w[CW-1:DATA_W];
   endfunction

   logic [CW-1:0]        mem_q [DEPTH];

   state_t               state_q,      state_d;
   logic [ADDR_W-1:0]    init_ptr_q,   init_ptr_d;
   logic                 init_done_q,  init_done_d;
   logic [CNT_W-1:0]     intv_cnt_q,   intv_cnt_d;
   logic                 scrub_pend_q, scrub_pend_d;
   logic [ADDR_W-1:0]    scrub_ptr_q,  scrub_ptr_d;
   logic                 rsp_valid_q,  rsp_valid_d;
   logic [DATA_W-1:0]    rsp_data_q,   rsp_data_d;
   logic                 rsp_err_q,    rsp_err_d;
   logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;
   logic [ADDR_W-1:0]    err_addr_q,   err_addr_d;
   logic                 err_av_q,     err_av_d;

   logic                 w_ready;
   logic                 w_host_rd;
   logic                 w_host_wr;
   logic                 w_scrub;
   logic [CW-1:0]        w_rd_word;
   logic [CW-1:0]        w_scrub_word;
   logic                 w_host_err;
   logic                 w_scrub_err;
   logic                 w_err;
   logic [ADDR_W-1:0]    w_err_addr;
   logic                 w_mem_we;
   logic [ADDR_W-1:0]    w_mem_waddr;
   logic [CW-1:0]        w_mem_wdata;

   assign w_ready      = (state_q == ST_IDLE) && !scrub_pend_q;
   assign w_host_rd    = req_valid && w_ready && !req_we;
   assign w_host_wr    = req_valid && w_ready && req_we;
   assign w_scrub      = (state_q == ST_IDLE) && scrub_pend_q;
   assign w_rd_word    = mem_q[req_addr];
   assign w_scrub_word = mem_q[scrub_ptr_q];
   assign w_host_err   = w_host_rd && berger_bad(w_rd_word);
   assign w_scrub_err  = w_scrub && berger_bad(w_scrub_word);
   assign w_err        = w_host_err || w_scrub_err;
   assign w_err_addr   = w_scrub ? scrub_ptr_q : req_addr;

   // Writes are gated by rst so an asserted reset never disturbs the array.
   assign w_mem_we    = rst && ((state_q == ST_INIT) || w_host_wr);
   assign w_mem_waddr = (state_q == ST_INIT) ? init_ptr_q : req_addr;
   assign w_mem_wdata = (state_q == ST_INIT) ? INIT_WORD
                                             : ({zeros_of(req_wdata), req_wdata} | inj_mask);

   always_ff @(posedge clk) begin
      if (w_mem_we) mem_q[w_mem_waddr] <= w_mem_wdata;
   end

   always_comb begin
      state_d      = state_q;
      init_ptr_d   = init_ptr_q;
      init_done_d  = init_done_q;
      intv_cnt_d   = intv_cnt_q;
      scrub_pend_d = scrub_pend_q;
      scrub_ptr_d  = scrub_ptr_q;

      case (state_q)
         ST_INIT: begin
            init_ptr_d = init_ptr_q + ADDR_ONE;
            if (init_ptr_q == PTR_LAST) begin
               state_d     = ST_IDLE;
               init_done_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (scrub_pend_q) begin
               scrub_pend_d = 1'b0;
               scrub_ptr_d  = scrub_ptr_q + ADDR_ONE;
            end
            // The interval only runs while no scrub is waiting, giving a period of INTERVAL+1.
            if (!scrub_en) begin
               intv_cnt_d = '0;
            end else if (!scrub_pend_q) begin
               if (intv_cnt_q == CNT_LAST) begin
                  intv_cnt_d   = '0;
                  scrub_pend_d = 1'b1;
               end else begin
                  intv_cnt_d = intv_cnt_q + CNT_ONE;
               end
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_comb begin
      rsp_valid_d = w_host_rd;
      rsp_data_d  = w_host_rd ? w_rd_word[DATA_W-1:0] : rsp_data_q;
      rsp_err_d   = w_host_err;

      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      err_av_d    = err_av_q;
      // A new error takes priority over a simultaneous clear.
      if (w_err) begin
         if (err_clr) begin
            err_count_d = ERR_ONE;
            err_addr_d  = w_err_addr;
            err_av_d    = 1'b1;
         end else begin
            if (err_count_q != ERR_MAX) err_count_d = err_count_q + ERR_ONE;
            if (!err_av_q) begin
               err_addr_d = w_err_addr;
               err_av_d   = 1'b1;
            end
         end
      end else if (err_clr) begin
         err_count_d = '0;
         err_addr_d  = '0;
         err_av_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_INIT;
         init_ptr_q   <= '0;
         init_done_q  <= 1'b0;
         intv_cnt_q   <= '0;
         scrub_pend_q <= 1'b0;
         scrub_ptr_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         err_count_q  <= '0;
         err_addr_q   <= '0;
         err_av_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_ptr_q   <= init_ptr_d;
         init_done_q  <= init_done_d;
         intv_cnt_q   <= intv_cnt_d;
         scrub_pend_q <= scrub_pend_d;
         scrub_ptr_q  <= scrub_ptr_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_err_q    <= rsp_err_d;
         err_count_q  <= err_count_d;
         err_addr_q   <= err_addr_d;
         err_av_q     <= err_av_d;
      end
   end

   assign req_ready      = w_ready;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_err        = rsp_err_q;
   assign err_count      = err_count_q;
   assign err_addr       = err_addr_q;
   assign err_addr_valid = err_av_q;
   assign init_done      = init_done_q;

endmodule
`default_nettype wire
